// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer
//   Sequencing controller for the calculator's multiply/divide unit. It takes
//   one request at a time. A MUL drives the external combinational array
//   multiplier through registered operands and samples the product after a
//   fixed settle time. A DIV runs an internal restoring divider that produces
//   one quotient bit per cycle.
//
// Ports
//   clk, rst_n               clock; asynchronous active-low reset
//   start_valid/start_ready  request handshake (ready only in IDLE)
//   op, a, b                 0=mul / 1=div, operands (sampled on acceptance)
//   mul_a, mul_b, mul_p      external multiplier operands / product
//   res_valid/res_ready      result handshake
//   result                   MUL: product; DIV: {remainder, quotient}
//   div_by_zero              DIV with b==0; valid with res_valid
//   busy                     state != IDLE
module mul_div_sequencer #(
  parameter int N        = 8,
  parameter int MUL_WAIT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic           op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [2*N-1:0] mul_p,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*N-1:0] result,
  output logic           div_by_zero,
  output logic           busy
);

  // The counter must hold both N-1 and MUL_WAIT-1.
  localparam int CMAX = (N > MUL_WAIT) ? N : MUL_WAIT;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  rem, quo, div_b;
  logic [N:0]    trial;
  logic [N-1:0]  rem_nxt, quo_nxt;

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // One restoring-division step. The trial difference's MSB is the borrow:
  // if it is set, the shifted remainder is kept.
  always_comb begin
    trial   = {rem, quo[N-1]} - {1'b0, div_b};
    rem_nxt = {rem[N-2:0], quo[N-1]};
    quo_nxt = {quo[N-2:0], 1'b0};
    if (!trial[N]) begin
      rem_nxt = trial[N-1:0];
      quo_nxt = {quo[N-2:0], 1'b1};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_valid) state_nxt = !op ? MUL : ((b != '0) ? DIV : DONE);
      MUL:  if (cnt == '0) state_nxt = DONE;
      DIV:  if (cnt == '0) state_nxt = DONE;
      DONE: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a       <= '0;
      mul_b       <= '0;
      result      <= '0;
      res_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      div_b       <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          div_by_zero <= 1'b0;
          if (!op) begin
            // Operands stay on the multiplier until the next accepted MUL.
            mul_a <= a;
            mul_b <= b;
            cnt   <= CW'(MUL_WAIT - 1);
          end else if (b != '0) begin
            rem   <= '0;
            quo   <= a;
            div_b <= b;
            cnt   <= CW'(N - 1);
          end else begin
            // Divide by zero: all-ones quotient, dividend as remainder.
            result      <= {a, {N{1'b1}}};
            div_by_zero <= 1'b1;
            res_valid   <= 1'b1;
          end
        end
        MUL: begin
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            result    <= mul_p;
            res_valid <= 1'b1;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            result    <= {rem_nxt, quo_nxt};
            res_valid <= 1'b1;
          end
        end
        DONE: if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
module tb_mul_div_sequencer;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_valid, start_ready, op;
  logic [N-1:0]   a, b, mul_a, mul_b;
  logic [2*N-1:0] mul_p, result;
  logic           res_valid, res_ready, div_by_zero, busy;

  int checks   = 0;
  int failures = 0;

  // External combinational array multiplier.
  assign mul_p = mul_a * mul_b;

  mul_div_sequencer #(.N(N), .MUL_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .a(a), .b(b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge (the acceptance edge E0).
  task automatic issue(input logic o, input logic [N-1:0] av, input logic [N-1:0] bv);
    start_valid = 1'b1; op = o; a = av; b = bv;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic release_res(input string tag);
    res_ready = 1'b1;
    tick();
    chk({tag, "_rv_low"}, 32'(res_valid), 32'd0);
    chk({tag, "_ready"}, 32'(start_ready), 32'd1);
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; op = 1'b0; a = '0; b = '0; res_ready = 1'b0;
    #12;
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_res_valid",   32'(res_valid),   32'd0);
    chk("rst_result",      32'(result),      32'd0);
    chk("rst_mul_a",       32'(mul_a),       32'd0);
    chk("rst_busy",        32'(busy),        32'd0);
    chk("rst_dbz",         32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    tick();

    // MUL 13*11
    issue(1'b0, 8'd13, 8'd11);
    chk("mul1_mul_a", 32'(mul_a), 32'd13);
    chk("mul1_mul_b", 32'(mul_b), 32'd11);
    chk("mul1_busy",  32'(busy), 32'd1);
    chk("mul1_sready", 32'(start_ready), 32'd0);
    chk("mul1_rv_e0", 32'(res_valid), 32'd0);
    tick();
    chk("mul1_rv_e1", 32'(res_valid), 32'd0);
    tick();
    chk("mul1_rv_e2", 32'(res_valid), 32'd1);
    chk("mul1_result", 32'(result), 32'h008F);
    chk("mul1_dbz", 32'(div_by_zero), 32'd0);
    release_res("mul1");

    // MUL 255*255
    issue(1'b0, 8'd255, 8'd255);
    tick(); tick();
    chk("mul2_rv", 32'(res_valid), 32'd1);
    chk("mul2_result", 32'(result), 32'hFE01);
    release_res("mul2");

    // DIV 200/7
    issue(1'b1, 8'd200, 8'd7);
    repeat (7) tick();
    chk("div1_rv_e7", 32'(res_valid), 32'd0);
    tick();
    chk("div1_rv_e8", 32'(res_valid), 32'd1);
    chk("div1_result", 32'(result), 32'h041C);
    chk("div1_dbz", 32'(div_by_zero), 32'd0);
    release_res("div1");

    // DIV 5/9
    issue(1'b1, 8'd5, 8'd9);
    repeat (8) tick();
    chk("div2_rv", 32'(res_valid), 32'd1);
    chk("div2_result", 32'(result), 32'h0500);
    release_res("div2");

    // DIV by zero: goes straight to DONE on the acceptance edge
    issue(1'b1, 8'h5A, 8'd0);
    chk("dbz_rv", 32'(res_valid), 32'd1);
    chk("dbz_result", 32'(result), 32'h5AFF);
    chk("dbz_flag", 32'(div_by_zero), 32'd1);
    release_res("dbz");

    // Following MUL clears div_by_zero at acceptance
    issue(1'b0, 8'd3, 8'd4);
    chk("dbz_clear", 32'(div_by_zero), 32'd0);
    tick(); tick();
    chk("mul3_result", 32'(result), 32'h000C);

    // Back-pressure: requests while in DONE are ignored
    op = 1'b0; a = 8'd1; b = 8'd1;
    for (int i = 0; i < 5; i++) begin
      start_valid = ~start_valid;
      tick();
      chk("bp_result", 32'(result), 32'h000C);
      chk("bp_sready", 32'(start_ready), 32'd0);
      chk("bp_rv", 32'(res_valid), 32'd1);
      chk("bp_mul_a", 32'(mul_a), 32'd3);
    end
    start_valid = 1'b0;
    release_res("bp");
    issue(1'b0, 8'd2, 8'd5);
    chk("bp_next_busy", 32'(busy), 32'd1);
    chk("bp_next_mul_a", 32'(mul_a), 32'd2);
    tick(); tick();
    chk("bp_next_result", 32'(result), 32'h000A);
    release_res("bp_next");

    // Asynchronous reset in the middle of DIV 200/7
    issue(1'b1, 8'd200, 8'd7);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_rv", 32'(res_valid), 32'd0);
    chk("arst_mul_a", 32'(mul_a), 32'd0);
    chk("arst_mul_b", 32'(mul_b), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sready", 32'(start_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_rv_hold", 32'(res_valid), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("arst_rel_sready", 32'(start_ready), 32'd1);
    issue(1'b1, 8'd200, 8'd7);
    repeat (7) tick();
    chk("div3_rv_e7", 32'(res_valid), 32'd0);
    tick();
    chk("div3_rv_e8", 32'(res_valid), 32'd1);
    chk("div3_result", 32'(result), 32'h041C);
    release_res("div3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
